// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared definitions for the bit-serial subtractor.
//   state_t        : controller states (IDLE, SHIFT, DONE); 2'b11 is illegal.
//   WIDTH_DEFAULT  : default operand/result width.
package serial_sub_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage : serial_sub_pkg

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit full subtractor cell, d = a - b - bin.
//   a_i    : minuend bit
//   b_i    : subtrahend bit
//   bin_i  : borrow in
//   d_o    : difference bit
//   bout_o : borrow out
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = a_i ^ b_i ^ bin_i;
  // Borrow when b exceeds a outright, or when they are equal and a borrow ripples in.
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial D = A - B - Bin, one bit per clock, LSB first.
//
// Handshake: start_i is sampled only while idle; the operands are captured on
// that edge. busy_o is high from the cycle after acceptance until the cycle
// after done_o. done_o pulses for one cycle, in the same cycle D_o/Bout_o
// (and V_o) first show the new result. Results are held until the next
// completion or reset.
//
// Ports:
//   clk_i, rst_n_i : clock (rising edge), asynchronous active-low reset
//   start_i        : launch request
//   A_i, B_i, Bin_i: minuend, subtrahend, borrow-in
//   D_o, Bout_o    : registered difference and final borrow-out
//   busy_o, done_o : status, decoded from the state register
//   dbg_state_o    : current controller state, for observation
//   V_o            : signed overflow (only with SERIAL_SUB_OVF_EN defined)
//
// Build option: define SERIAL_SUB_OVF_EN to add the V_o overflow output.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEFAULT,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             Bin_i,
  output logic [WIDTH-1:0] D_o,
  output logic             Bout_o,
`ifdef SERIAL_SUB_OVF_EN
  output logic             V_o,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       dbg_state_o
);

  state_t             state, state_next;
  logic [WIDTH-1:0]   a_sr, b_sr, r_sr;
  logic               brw;
  logic [CNT_W-1:0]   cnt;
  logic               bit_d, bit_bout;
  logic               last_bit;

`ifdef SERIAL_SUB_OVF_EN
  logic               a_msb, b_msb;
`endif

  full_subtractor u_fs (
    .a_i    (a_sr[0]),
    .b_i    (b_sr[0]),
    .bin_i  (brw),
    .d_o    (bit_d),
    .bout_o (bit_bout)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = start_i ? SHIFT : IDLE;
      SHIFT:   state_next = last_bit ? DONE : SHIFT;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy_o      = (state == SHIFT) || (state == DONE);
  assign done_o      = (state == DONE);
  assign dbg_state_o = state;

  // Datapath: operand capture, serial shift and result registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      D_o    <= '0;
      Bout_o <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      V_o    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            a_sr  <= A_i;
            b_sr  <= B_i;
            brw   <= Bin_i;
            cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= A_i[WIDTH-1];
            b_msb <= B_i[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          a_sr <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr <= {1'b0, b_sr[WIDTH-1:1]};
          r_sr <= {bit_d, r_sr[WIDTH-1:1]};
          brw  <= bit_bout;
          cnt  <= cnt + CNT_W'(1);
          if (last_bit) begin
            // The bit produced on this edge is the result MSB.
            D_o    <= {bit_d, r_sr[WIDTH-1:1]};
            Bout_o <= bit_bout;
`ifdef SERIAL_SUB_OVF_EN
            V_o    <= (a_msb ^ b_msb) & (a_msb ^ bit_d);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed bench for serial_subtractor
// (WIDTH = 4). A transaction-level model predicts results and status every
// cycle; directed cases pin the model with hand-computed values.
// Define SERIAL_SUB_OVF_EN to also cover V_o.
module tb_serial_subtractor;

  localparam int W  = 4;
  localparam int QW = W + 2;  // {v, bout, d}

  logic         clk_i = 1'b0;
  logic         rst_n_i = 1'b0;
  logic         start_i = 1'b0;
  logic [W-1:0] A_i = '0;
  logic [W-1:0] B_i = '0;
  logic         Bin_i = 1'b0;
  logic [W-1:0] D_o;
  logic         Bout_o;
  logic         busy_o;
  logic         done_o;
  logic [1:0]   dbg_state_o;
`ifdef SERIAL_SUB_OVF_EN
  logic         V_o;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (start_i),
    .A_i         (A_i),
    .B_i         (B_i),
    .Bin_i       (Bin_i),
    .D_o         (D_o),
    .Bout_o      (Bout_o),
`ifdef SERIAL_SUB_OVF_EN
    .V_o         (V_o),
`endif
    .busy_o      (busy_o),
    .done_o      (done_o),
    .dbg_state_o (dbg_state_o)
  );

  task automatic check(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
  endtask

  // ---------------- reference model ----------------
  // Accepted ops occupy WIDTH+1 busy cycles; the result appears in the last.
  logic [QW-1:0] exp_q[$];
  int            busy_left = 0;
  logic [W-1:0]  exp_d = '0;
  logic          exp_b = 1'b0;
  logic          exp_v = 1'b0;

  function automatic logic [QW-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bin);
    int           full;
    logic [W-1:0] d;
    logic         v;
    full = int'(a) - int'(b) - int'(bin);
    d    = W'(full & ((1 << W) - 1));
    v    = (a[W-1] != b[W-1]) && (a[W-1] != d[W-1]);
    return {v, (full < 0), d};
  endfunction

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_left = 0;
      exp_d = '0; exp_b = 1'b0; exp_v = 1'b0;
      exp_q.delete();
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 1) begin
        if (exp_q.size() == 0) check("model_queue_empty", 0, 1);
        else {exp_v, exp_b, exp_d} = exp_q.pop_front();
      end
    end else if (start_i) begin
      busy_left = W + 1;
      exp_q.push_back(ref_op(A_i, B_i, Bin_i));
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_i) begin
    check("busy", int'(busy_o), int'(busy_left > 0));
    check("done", int'(done_o), int'(busy_left == 1));
    check("d",    int'(D_o),    int'(exp_d));
    check("bout", int'(Bout_o), int'(exp_b));
`ifdef SERIAL_SUB_OVF_EN
    check("v",    int'(V_o),    int'(exp_v));
`endif
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; launches one op, randomizes operands after acceptance,
  // returns when the DUT is idle again.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        output int latency, output int busy_cycles);
    int  n;
    bit  seen_done;
    A_i = a; B_i = b; Bin_i = bin; start_i = 1'b1;
    latency = 0; busy_cycles = 0; seen_done = 0;
    for (n = 1; n <= 30; n++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      A_i = W'($urandom); B_i = W'($urandom); Bin_i = 1'($urandom);
      if (busy_o) busy_cycles++;
      if (done_o && !seen_done) begin seen_done = 1; latency = n; end
      if (seen_done && !busy_o) break;
    end
    if (!seen_done) check("op_timeout", 0, 1);
  endtask

  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin, input int exp_dv, input int exp_bv);
    int lat, bc;
    run_op(a, b, bin, lat, bc);
    check({name, "_d"},       int'(D_o),    exp_dv);
    check({name, "_bout"},    int'(Bout_o), exp_bv);
    check({name, "_latency"}, lat, W + 1);
    check({name, "_busy"},    bc,  W + 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, bc, dones;
    repeat (2) @(negedge clk_i);
    check("rst_d", int'(D_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    directed("a3_b7", 4'd3, 4'd7, 1'b0, 12, 1);

    // Abort an op with an asynchronous reset in its second SHIFT cycle.
    A_i = 4'd10; B_i = 4'd5; Bin_i = 1'b0; start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    @(negedge clk_i);
    #2 rst_n_i = 1'b0;
    #1;
    check("abort_d", int'(D_o), 0);
    check("abort_bout", int'(Bout_o), 0);
    check("abort_busy", int'(busy_o), 0);
    check("abort_done", int'(done_o), 0);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    directed("a10_b5", 4'd10, 4'd5, 1'b0, 5, 0);
    directed("a2_b3_bin", 4'd2, 4'd3, 1'b1, 14, 1);
    directed("a15_b15", 4'd15, 4'd15, 1'b0, 0, 0);  // back-to-back with the previous op

`ifdef SERIAL_SUB_OVF_EN
    run_op(4'b0111, 4'b1000, 1'b0, lat, bc);
    check("ovf_d", int'(D_o), 15);
    check("ovf_v", int'(V_o), 1);
    run_op(4'd5, 4'd3, 1'b0, lat, bc);
    check("noovf_d", int'(D_o), 2);
    check("noovf_v", int'(V_o), 0);
`endif

    // start_i held high, operands changing every cycle.
    dones = 0;
    A_i = W'($urandom); B_i = W'($urandom); Bin_i = 1'($urandom);
    start_i = 1'b1;
    for (int i = 0; i < 3 * (W + 2); i++) begin
      @(negedge clk_i);
      if (done_o) dones++;
      A_i = W'($urandom); B_i = W'($urandom); Bin_i = 1'($urandom);
    end
    start_i = 1'b0;
    check("held_start_dones", dones, 3);
    @(negedge clk_i);

    // Random ops with random idle gaps.
    for (int k = 0; k < 40; k++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), lat, bc);
      check("rand_latency", lat, W + 1);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end

    repeat (3) @(negedge clk_i);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule : tb_serial_subtractor
